// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: op classes, MIPS opcodes, word formats and FSM states shared by the instruction encoder
package instr_enc_pkg;
  typedef enum logic [4:0] {
    OP_R, OP_LW, OP_LH, OP_LB, OP_LBU, OP_LHU, OP_SW, OP_SH, OP_SB,
    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_J, OP_JAL, OP_LI, OP_FPU_R, OP_LWC1, OP_SWC1
  } op_e;
  localparam logic [5:0] OPC_R     = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_BLEZ  = 6'h06;
  localparam logic [5:0] OPC_BGTZ  = 6'h07;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_COP1  = 6'h11;
  localparam logic [5:0] OPC_LB    = 6'h20;
  localparam logic [5:0] OPC_LH    = 6'h21;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_LBU   = 6'h24;
  localparam logic [5:0] OPC_LHU   = 6'h25;
  localparam logic [5:0] OPC_SB    = 6'h28;
  localparam logic [5:0] OPC_SH    = 6'h29;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_LWC1  = 6'h31;
  localparam logic [5:0] OPC_SWC1  = 6'h39;
  localparam logic [4:0] FMT_SINGLE = 5'h10;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_J, FMT_FPU, FMT_BAD} fmt_e;
  typedef enum logic [1:0] {IDLE, ONE, LI_HI, LI_LO} state_e;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational op class + fields -> 32-bit MIPS word, range_err, illegal
//   ports: op, rs, rt, rd, shamt, funct, imm, target in; word, range_err, illegal out
//   INSTR_ENC_FPU_EN enables OP_FPU_R, OP_LWC1, OP_SWC1; otherwise they report illegal
module instr_pack
  import instr_enc_pkg::*;
(
  input  op_e         op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [31:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        range_err,
  output logic        illegal
);
  logic [5:0] opc;
  fmt_e       fmt;
  logic       sgn, zx;
  logic [4:0] rs_f, rt_f;
  always_comb begin
    opc = OPC_R;
    fmt = FMT_I;
    sgn = 1'b0;
    zx  = 1'b0;
    case (op)
      OP_R:     fmt = FMT_R;
      OP_LW:    begin opc = OPC_LW;    sgn = 1'b1; end
      OP_LH:    begin opc = OPC_LH;    sgn = 1'b1; end
      OP_LB:    begin opc = OPC_LB;    sgn = 1'b1; end
      OP_LBU:   begin opc = OPC_LBU;   sgn = 1'b1; end
      OP_LHU:   begin opc = OPC_LHU;   sgn = 1'b1; end
      OP_SW:    begin opc = OPC_SW;    sgn = 1'b1; end
      OP_SH:    begin opc = OPC_SH;    sgn = 1'b1; end
      OP_SB:    begin opc = OPC_SB;    sgn = 1'b1; end
      OP_BEQ:   begin opc = OPC_BEQ;   sgn = 1'b1; end
      OP_BNE:   begin opc = OPC_BNE;   sgn = 1'b1; end
      OP_BLEZ:  begin opc = OPC_BLEZ;  sgn = 1'b1; end
      OP_BGTZ:  begin opc = OPC_BGTZ;  sgn = 1'b1; end
      OP_ADDI:  begin opc = OPC_ADDI;  sgn = 1'b1; end
      OP_ADDIU: begin opc = OPC_ADDIU; sgn = 1'b1; end
      OP_SLTI:  begin opc = OPC_SLTI;  sgn = 1'b1; end
      OP_SLTIU: begin opc = OPC_SLTIU; sgn = 1'b1; end
      OP_ANDI:  begin opc = OPC_ANDI;  zx = 1'b1; end
      OP_ORI:   begin opc = OPC_ORI;   zx = 1'b1; end
      OP_XORI:  begin opc = OPC_XORI;  zx = 1'b1; end
      OP_LUI:   begin opc = OPC_LUI;   zx = 1'b1; end
      OP_J:     begin opc = OPC_J;     fmt = FMT_J; end
      OP_JAL:   begin opc = OPC_JAL;   fmt = FMT_J; end
`ifdef INSTR_ENC_FPU_EN
      OP_FPU_R: fmt = FMT_FPU;
      OP_LWC1:  begin opc = OPC_LWC1;  sgn = 1'b1; end
      OP_SWC1:  begin opc = OPC_SWC1;  sgn = 1'b1; end
`endif
      default:  fmt = FMT_BAD;
    endcase
  end
  // LUI has no rs operand and BLEZ/BGTZ compare against $0, so those fields are forced
  assign rs_f = op == OP_LUI ? 5'd0 : rs;
  assign rt_f = (op == OP_BLEZ || op == OP_BGTZ) ? 5'd0 : rt;
  assign word = fmt == FMT_R   ? {OPC_R, rs, rt, rd, shamt, funct} :
                fmt == FMT_J   ? {opc, target} :
                fmt == FMT_FPU ? {OPC_COP1, FMT_SINGLE, rt, rs, rd, funct} :
                fmt == FMT_I   ? {opc, rs_f, rt_f, imm[15:0]} : 32'd0;
  // signed fit: bits 31..15 must all replicate the 16-bit sign bit
  assign range_err = (sgn && imm[31:15] != {17{imm[15]}}) || (zx && imm[31:16] != 16'd0);
  assign illegal   = fmt == FMT_BAD;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs op requests into MIPS words and streams them with byte addresses to imem
//   in:  clk, reset (sync, active-high), in_valid, op_sel, rs, rt, rd, shamt, funct, imm, target, out_ready
//   out: in_ready, out_valid, out_instr, out_addr, range_err (sticky), illegal (sticky)
//   LI expands to lui+ori, or a single ori when imm[31:16]==0
//   INSTR_ENC_FPU_EN enables the FPU op classes inside instr_pack
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [31:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              range_err,
  output logic              illegal
);
  state_e      state, state_n;
  logic        in_fire, out_fire, is_li, li_hi, load;
  logic [4:0]  rt_q;
  logic [15:0] lo_q;
  op_e         p_op;
  logic [4:0]  p_rs, p_rt;
  logic [31:0] p_imm, p_word;
  logic        p_rerr, p_ill;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign is_li    = op_sel == OP_LI;
  assign li_hi    = imm[31:16] != 16'd0;
  // One packer serves both the incoming request and the deferred ori half of an LI;
  // in_ready is low in LI_HI, so the two uses never collide.
  assign p_op  = state == LI_HI ? OP_ORI : is_li ? (li_hi ? OP_LUI : OP_ORI) : op_e'(op_sel);
  assign p_rs  = state == LI_HI ? rt_q : is_li ? 5'd0 : rs;
  assign p_rt  = state == LI_HI ? rt_q : rt;
  assign p_imm = state == LI_HI ? {16'd0, lo_q} : is_li ? {16'd0, li_hi ? imm[31:16] : imm[15:0]} : imm;
  instr_pack u_pack (
    .op(p_op), .rs(p_rs), .rt(p_rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(p_imm), .target(target), .word(p_word), .range_err(p_rerr), .illegal(p_ill)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == LI_HI) state_n = out_fire ? LI_LO : LI_HI;
    else if (in_fire) state_n = p_ill ? IDLE : (is_li && li_hi) ? LI_HI : ONE;
    else if (out_fire) state_n = IDLE;
  end
  always_comb begin
    out_valid = state != IDLE;
    in_ready  = state == IDLE || ((state == ONE || state == LI_LO) && out_ready);
  end
  assign load = (state == LI_HI && out_fire) || (in_fire && !p_ill);
  always_ff @(posedge clk)
    if (reset) begin
      out_instr <= '0;
      out_addr  <= BASE_ADDR;
      range_err <= 1'b0;
      illegal   <= 1'b0;
      rt_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (out_fire) out_addr <= out_addr + ADDR_W'(4);
      if (load) out_instr <= p_word;
      if (in_fire && p_rerr) range_err <= 1'b1;
      if (in_fire && p_ill) illegal <= 1'b1;
      if (in_fire) begin
        rt_q <= rt;
        lo_q <= imm[15:0];
      end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized self-checking bench for instr_encoder against a field-level reference model
module tb_instr_encoder;
  import instr_enc_pkg::*;
`ifdef INSTR_ENC_FPU_EN
  localparam bit FPU = 1'b1;
`else
  localparam bit FPU = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready;
  logic        in_ready, out_valid, range_err, illegal;
  logic [4:0]  op_sel = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [31:0] imm = '0, out_instr, out_addr;
  logic [25:0] target = '0;
  int          n_cmp = 0, n_bad = 0, mode = 0, cyc = 0;
  logic [31:0] exp_w[$], exp_a[$], obs_w[$], obs_a[$];
  logic [31:0] exp_addr = BASE;
  bit          exp_rerr = 1'b0, exp_ill = 1'b0;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .range_err(range_err), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(($urandom % 4) != 0) : 1'b0;
  end
  always @(negedge clk)
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      obs_w.push_back(out_instr);
      obs_a.push_back(out_addr);
    end

  function automatic void push(logic [31:0] w);
    exp_w.push_back(w);
    exp_a.push_back(exp_addr);
    exp_addr += 4;
  endfunction

  function automatic void model(logic [4:0] op, logic [31:0] s_, t_, d_, h_, f_, v_, tg_);
    int          opc = -1;
    bit          sg = 1'b0, zx = 1'b0;
    logic [31:0] s = s_, t = t_;
    longint      v = longint'($signed(v_));
    case (op)
      OP_R:     begin push((s << 21) | (t << 16) | (d_ << 11) | (h_ << 6) | f_); return; end
      OP_J:     begin push((32'd2 << 26) | tg_); return; end
      OP_JAL:   begin push((32'd3 << 26) | tg_); return; end
      OP_LI: begin
        if (v_ < 32'h10000) push((32'h0D << 26) | (t << 16) | v_);
        else begin
          push((32'h0F << 26) | (t << 16) | (v_ >> 16));
          push((32'h0D << 26) | (t << 21) | (t << 16) | (v_ & 32'hFFFF));
        end
        return;
      end
      OP_FPU_R: begin
        if (FPU) push((32'h11 << 26) | (32'h10 << 21) | (t << 16) | (s << 11) | (d_ << 6) | f_);
        else exp_ill = 1'b1;
        return;
      end
      OP_LW:    begin opc = 'h23; sg = 1'b1; end
      OP_LH:    begin opc = 'h21; sg = 1'b1; end
      OP_LB:    begin opc = 'h20; sg = 1'b1; end
      OP_LBU:   begin opc = 'h24; sg = 1'b1; end
      OP_LHU:   begin opc = 'h25; sg = 1'b1; end
      OP_SW:    begin opc = 'h2B; sg = 1'b1; end
      OP_SH:    begin opc = 'h29; sg = 1'b1; end
      OP_SB:    begin opc = 'h28; sg = 1'b1; end
      OP_BEQ:   begin opc = 'h04; sg = 1'b1; end
      OP_BNE:   begin opc = 'h05; sg = 1'b1; end
      OP_BLEZ:  begin opc = 'h06; sg = 1'b1; t = 0; end
      OP_BGTZ:  begin opc = 'h07; sg = 1'b1; t = 0; end
      OP_ADDI:  begin opc = 'h08; sg = 1'b1; end
      OP_ADDIU: begin opc = 'h09; sg = 1'b1; end
      OP_SLTI:  begin opc = 'h0A; sg = 1'b1; end
      OP_SLTIU: begin opc = 'h0B; sg = 1'b1; end
      OP_ANDI:  begin opc = 'h0C; zx = 1'b1; end
      OP_ORI:   begin opc = 'h0D; zx = 1'b1; end
      OP_XORI:  begin opc = 'h0E; zx = 1'b1; end
      OP_LUI:   begin opc = 'h0F; zx = 1'b1; s = 0; end
      OP_LWC1:  if (FPU) begin opc = 'h31; sg = 1'b1; end
      OP_SWC1:  if (FPU) begin opc = 'h39; sg = 1'b1; end
      default:  opc = -1;
    endcase
    if (opc < 0) begin
      exp_ill = 1'b1;
      return;
    end
    if ((sg && (v < -32768 || v > 32767)) || (zx && v_ > 32'hFFFF)) exp_rerr = 1'b1;
    push((32'(opc) << 26) | (s << 21) | (t << 16) | (v_ & 32'hFFFF));
  endfunction

  task automatic send(input logic [4:0] op, rs_, rt_, rd_, sh_, input logic [5:0] fn_,
                      input logic [31:0] imm_, input logic [25:0] tg_);
    int k = 0;
    op_sel = op; rs = rs_; rt = rt_; rd = rd_; shamt = sh_; funct = fn_; imm = imm_; target = tg_;
    in_valid = 1'b1;
    model(op, 32'(rs_), 32'(rt_), 32'(rd_), 32'(sh_), 32'(fn_), imm_, 32'(tg_));
    do begin
      @(negedge clk);
      k++;
    end while (in_ready !== 1'b1 && k < 100);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_timeout op=%0d in_ready=%b want 1 within 100 cycles", op, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (obs_w.size() < exp_w.size() && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_w.size() != exp_w.size()) begin
      n_bad++;
      $display("FAIL %s_count got %0d words want %0d", tag, obs_w.size(), exp_w.size());
    end
    while (exp_w.size() > 0 && obs_w.size() > 0) begin
      logic [31:0] ew, ea, ow, oa;
      ew = exp_w.pop_front(); ea = exp_a.pop_front();
      ow = obs_w.pop_front(); oa = obs_a.pop_front();
      n_cmp++;
      if (ow !== ew || oa !== ea) begin
        n_bad++;
        $display("FAIL %s_word got %h@%h want %h@%h", tag, ow, oa, ew, ea);
      end
    end
    exp_w.delete(); exp_a.delete(); obs_w.delete(); obs_a.delete();
    n_cmp++;
    if (range_err !== exp_rerr || illegal !== exp_ill) begin
      n_bad++;
      $display("FAIL %s_flags got range_err=%b illegal=%b want %b %b", tag, range_err, illegal, exp_rerr, exp_ill);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_w.delete(); exp_a.delete(); obs_w.delete(); obs_a.delete();
    exp_addr = BASE; exp_rerr = 1'b0; exp_ill = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_addr !== BASE || range_err !== 1'b0 ||
        illegal !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset got v=%b instr=%h addr=%h re=%b il=%b rdy=%b want 0 0 %h 0 0 1",
               out_valid, out_instr, out_addr, range_err, illegal, in_ready, BASE);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_addi;
    send(OP_ADDI, 1, 2, 0, 0, 0, 32'd5, 0);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_instr !== 32'h20220005 || out_addr !== BASE || range_err !== 1'b0) begin
      n_bad++;
      $display("FAIL addi got v=%b %h@%h re=%b want 1 20220005@%h 0", out_valid, out_instr, out_addr, range_err, BASE);
    end
    drain("addi");
  endtask

  task automatic test_li;
    send(OP_LI, 0, 8, 0, 0, 0, 32'h12345678, 0);
    send(OP_LI, 0, 3, 0, 0, 0, 32'h000000FF, 0);
    send(OP_LI, 0, 31, 0, 0, 0, 32'hFFFF0000, 0);
    drain("li");
  endtask

  task automatic test_li_stall;
    mode = 2;
    send(OP_LI, 0, 8, 0, 0, 0, 32'h12345678, 0);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_instr !== 32'h3C081234 || in_ready !== 1'b0 || out_addr !== exp_a[0]) begin
        n_bad++;
        $display("FAIL li_stall got v=%b %h@%h rdy=%b want 1 3c081234@%h 0",
                 out_valid, out_instr, out_addr, in_ready, exp_a[0]);
      end
    end
    mode = 0;
    drain("li_stall");
  endtask

  task automatic test_forms;
    send(OP_J, 0, 0, 0, 0, 0, 0, 26'h100000);
    send(OP_JAL, 0, 0, 0, 0, 0, 0, 26'h3FFFFFF);
    send(OP_R, 4, 5, 6, 7, 6'h20, 0, 0);
    send(OP_BLEZ, 3, 9, 0, 0, 0, 32'hFFFF_FFFC, 0);
    send(OP_LUI, 7, 2, 0, 0, 0, 32'h0000_ABCD, 0);
    send(OP_SW, 29, 31, 0, 0, 0, 32'hFFFF_8000, 0);
    drain("forms");
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = cyc;
    send(OP_ORI, 1, 1, 0, 0, 0, 32'h1, 0);
    send(OP_ANDI, 2, 2, 0, 0, 0, 32'hFFFF, 0);
    send(OP_BNE, 3, 4, 0, 0, 0, 32'h7FFF, 0);
    send(OP_LB, 5, 6, 0, 0, 0, 32'h10, 0);
    n_cmp++;
    if (cyc - c0 != 4) begin
      n_bad++;
      $display("FAIL back_to_back got %0d cycles for 4 requests want 4", cyc - c0);
    end
    drain("b2b");
  endtask

  task automatic test_fpu;
    send(OP_FPU_R, 2, 4, 6, 0, 0, 0, 0);
    send(OP_LWC1, 1, 3, 0, 0, 0, 32'h8, 0);
    send(OP_ADDIU, 1, 1, 0, 0, 0, 32'h4, 0);
    drain("fpu");
    send(5'd30, 1, 1, 0, 0, 0, 0, 0);
    drain("illegal");
  endtask

  task automatic test_range;
    send(OP_ADDI, 1, 2, 0, 0, 0, 32'h0001_0000, 0);
    drain("range");
    n_cmp++;
    if (range_err !== 1'b1) begin
      n_bad++;
      $display("FAIL range_set got %b want 1", range_err);
    end
    send(OP_ADDI, 1, 2, 0, 0, 0, 32'h7, 0);
    send(OP_XORI, 1, 2, 0, 0, 0, 32'h1_0000, 0);
    drain("range_sticky");
  endtask

  task automatic test_random;
    mode = 1;
    for (int i = 0; i < 80; i++) begin
      logic [31:0] v;
      case ($urandom % 3)
        0: v = 32'($urandom_range(0, 65535)) - 32'd32768;
        1: v = {16'd0, 16'($urandom)};
        default: v = $urandom;
      endcase
      send(5'(($urandom % 8) == 0 ? $urandom_range(24, 31) : $urandom_range(0, 23)),
           5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), v, 26'($urandom));
    end
    mode = 0;
    drain("random");
  endtask

  initial begin
    test_reset;
    test_addi;
    test_li;
    test_li_stall;
    test_forms;
    test_back_to_back;
    test_fpu;
    test_range;
    test_reset;
    test_random;
    test_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
